// File: rtl/race_ctrl.sv
// Game-sequencing controller: enter-key sync, per-frame collision/finish sampling and race FSM.
// Optional elapsed-time counter is built only when RACE_TIMER_EN is defined.
module race_ctrl #(
   parameter int COUNTDOWN_FRAMES  = 180,
   parameter int CRASH_HOLD_FRAMES = 120,
   parameter int FRAMES_PER_SEC    = 60,
   parameter int COLLIDE_MIN       = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enter_key,
   input  logic       video_on,
   input  logic [9:0] pixel_x,
   input  logic [9:0] pixel_y,
   input  logic       car_on,
   input  logic       road_on,
   input  logic       finish_line,
   output logic       game_reset,
   output logic       pause,
   output logic       start_en,
   output logic       crash_en,
   output logic       finish_en,
   output logic [7:0] countdown,
   output logic [7:0] elapsed_sec
);

   typedef enum logic [2:0] {IDLE, COUNT, RUN, PAUSED, CRASH, FINISH} state_t;

   localparam int OFF_W = $clog2(COLLIDE_MIN + 1);
   localparam logic [OFF_W-1:0] OFF_MAX = OFF_W'(COLLIDE_MIN);
   localparam logic [15:0] CD_INIT   = 16'(COUNTDOWN_FRAMES);
   localparam logic [15:0] HOLD_INIT = 16'(CRASH_HOLD_FRAMES);

   state_t state, state_next;

   logic sync1, sync2, sync3;
   logic [1:0] valid_sr;
   logic armed, enter_p;
   logic at_frame, at_frame_d, frame_p;
   logic [OFF_W-1:0] off_cnt;
   logic fin_hit;
   logic [15:0] cd_cnt, hold_cnt;
   logic [16:0] cd_round;

   // A key held through reset must be seen low before any edge is accepted
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1    <= 1'b0;
         sync2    <= 1'b0;
         sync3    <= 1'b0;
         valid_sr <= 2'b00;
         armed    <= 1'b0;
         enter_p  <= 1'b0;
      end else begin
         sync1    <= enter_key;
         sync2    <= sync1;
         sync3    <= sync2;
         valid_sr <= {valid_sr[0], 1'b1};
         if (valid_sr[1] && !sync2)
            armed <= 1'b1;
         enter_p  <= armed & sync2 & ~sync3;
      end
   end

   assign at_frame = (pixel_y == 10'd481) && (pixel_x == 10'd0);
   assign frame_p  = at_frame & ~at_frame_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         at_frame_d <= 1'b0;
      else
         at_frame_d <= at_frame;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         off_cnt <= '0;
         fin_hit <= 1'b0;
      end else if (frame_p || state == PAUSED) begin
         off_cnt <= '0;
         fin_hit <= 1'b0;
      end else begin
         if (video_on && car_on && !road_on && off_cnt != OFF_MAX)
            off_cnt <= off_cnt + OFF_W'(1);
         if (video_on && car_on && finish_line)
            fin_hit <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      game_reset = 1'b0;
      pause      = 1'b0;
      start_en   = 1'b0;
      crash_en   = 1'b0;
      finish_en  = 1'b0;
      case (state)
         IDLE: begin
            game_reset = 1'b1;
            pause      = 1'b1;
            start_en   = 1'b1;
            if (enter_p)
               state_next = COUNT;
         end
         COUNT: begin
            pause = 1'b1;
            if (frame_p && cd_cnt == 16'd1)
               state_next = RUN;
         end
         RUN: begin
            // Crash outranks finish, which outranks a pause request
            if (frame_p && off_cnt == OFF_MAX)
               state_next = CRASH;
            else if (frame_p && fin_hit)
               state_next = FINISH;
            else if (enter_p)
               state_next = PAUSED;
         end
         PAUSED: begin
            pause = 1'b1;
            if (enter_p)
               state_next = RUN;
         end
         CRASH: begin
            pause    = 1'b1;
            crash_en = 1'b1;
            if (enter_p && hold_cnt == 16'd0)
               state_next = IDLE;
         end
         FINISH: begin
            pause     = 1'b1;
            finish_en = 1'b1;
            if (enter_p)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cd_cnt   <= '0;
         hold_cnt <= '0;
      end else begin
         if (state == IDLE && state_next == COUNT)
            cd_cnt <= CD_INIT;
         else if (state == COUNT && frame_p && cd_cnt != 16'd0)
            cd_cnt <= cd_cnt - 16'd1;
         if (state == RUN && state_next == CRASH)
            hold_cnt <= HOLD_INIT;
         else if (state == CRASH && frame_p && hold_cnt != 16'd0)
            hold_cnt <= hold_cnt - 16'd1;
      end
   end

   // Whole seconds remaining, rounded up so the display never shows 0 early
   always_comb begin
      cd_round  = {1'b0, cd_cnt} + 17'(FRAMES_PER_SEC - 1);
      countdown = 8'(cd_round / 17'(FRAMES_PER_SEC));
   end

`ifdef RACE_TIMER_EN
   localparam int SUB_W = $clog2(FRAMES_PER_SEC + 1);
   localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(FRAMES_PER_SEC - 1);

   logic [SUB_W-1:0] sub_cnt;
   logic [7:0]       sec_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sub_cnt <= '0;
         sec_cnt <= '0;
      end else if (state == IDLE && state_next == COUNT) begin
         sub_cnt <= '0;
         sec_cnt <= '0;
      end else if (state == RUN && frame_p) begin
         if (sub_cnt == SUB_MAX) begin
            sub_cnt <= '0;
            if (sec_cnt != 8'hFF)
               sec_cnt <= sec_cnt + 8'd1;
         end else begin
            sub_cnt <= sub_cnt + SUB_W'(1);
         end
      end
   end

   assign elapsed_sec = sec_cnt;
`else
   assign elapsed_sec = 8'd0;
`endif

endmodule

// File: tb/tb_race_ctrl.sv
// Directed bench for race_ctrl using a short synthetic frame (5 visible pixels + 4-clock tick line).
// Expected outputs are queued before each stimulus step and popped when the result is sampled.
module tb_race_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       enter_key;
   logic       video_on;
   logic [9:0] pixel_x;
   logic [9:0] pixel_y;
   logic       car_on;
   logic       road_on;
   logic       finish_line;
   logic       game_reset;
   logic       pause;
   logic       start_en;
   logic       crash_en;
   logic       finish_en;
   logic [7:0] countdown;
   logic [7:0] elapsed_sec;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      string       tag;
      logic [20:0] val;
   } exp_t;

   exp_t sb[$];

   // Control field order: game_reset, pause, start_en, crash_en, finish_en
   localparam logic [4:0] C_IDLE   = 5'b11100;
   localparam logic [4:0] C_COUNT  = 5'b01000;
   localparam logic [4:0] C_RUN    = 5'b00000;
   localparam logic [4:0] C_PAUSED = 5'b01000;
   localparam logic [4:0] C_CRASH  = 5'b01010;
   localparam logic [4:0] C_FINISH = 5'b01001;

   race_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .enter_key   (enter_key),
      .video_on    (video_on),
      .pixel_x     (pixel_x),
      .pixel_y     (pixel_y),
      .car_on      (car_on),
      .road_on     (road_on),
      .finish_line (finish_line),
      .game_reset  (game_reset),
      .pause       (pause),
      .start_en    (start_en),
      .crash_en    (crash_en),
      .finish_en   (finish_en),
      .countdown   (countdown),
      .elapsed_sec (elapsed_sec)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] el(input int run_frames);
`ifdef RACE_TIMER_EN
      return (run_frames / 60 > 255) ? 8'd255 : 8'(run_frames / 60);
`else
      return 8'd0;
`endif
   endfunction

   task automatic push_expected(input string tag, input logic [4:0] ctl,
                                input logic [7:0] cd, input logic [7:0] es);
      exp_t e;
      e.tag = tag;
      e.val = {ctl, cd, es};
      sb.push_back(e);
   endtask

   task automatic checkOutput();
      exp_t        e;
      logic [20:0] obs;
      obs = {game_reset, pause, start_en, crash_en, finish_en, countdown, elapsed_sec};
      checks++;
      if (sb.size() == 0) begin
         failures++;
         $error("FAIL scoreboard_empty observed=%h", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.val) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic idle_pixels();
      video_on    = 1'b0;
      car_on      = 1'b0;
      road_on     = 1'b1;
      finish_line = 1'b0;
      pixel_x     = 10'd0;
      pixel_y     = 10'd0;
   endtask

   // One frame: 20 visible clocks, the first off_clks of them off-road, optional finish overlap
   task automatic applyStimulus(input int off_clks, input bit fin);
      for (int c = 0; c < 20; c++) begin
         pixel_y     = 10'd0;
         pixel_x     = 10'(c / 4);
         video_on    = 1'b1;
         car_on      = (c < off_clks) || (fin && c == 19);
         road_on     = !(c < off_clks);
         finish_line = fin && (c == 19);
         tick(1);
      end
      idle_pixels();
      pixel_y = 10'd481;
      tick(4);
      idle_pixels();
   endtask

   task automatic frames(input int n, input int off_clks, input bit fin);
      for (int f = 0; f < n; f++)
         applyStimulus(off_clks, fin);
   endtask

   task automatic press(input int hold);
      enter_key = 1'b1;
      tick(hold);
      enter_key = 1'b0;
      tick(4);
   endtask

   task automatic hits(input int n);
      pixel_y     = 10'd0;
      video_on    = 1'b1;
      car_on      = 1'b1;
      road_on     = 1'b0;
      finish_line = 1'b1;
      tick(n);
      idle_pixels();
   endtask

   initial begin
      reset     = 1'b1;
      enter_key = 1'b0;
      idle_pixels();
      tick(3);
      push_expected("in_reset", C_IDLE, 8'd0, 8'd0);
      checkOutput();
      reset = 1'b0;
      tick(5);
      push_expected("after_reset", C_IDLE, 8'd0, 8'd0);
      checkOutput();

      // Enter latency and countdown steps
      push_expected("enter_k2_idle", C_IDLE, 8'd0, 8'd0);
      enter_key = 1'b1;
      tick(3);
      checkOutput();
      push_expected("enter_k3_count", C_COUNT, 8'd3, 8'd0);
      tick(1);
      checkOutput();
      push_expected("held_key_count", C_COUNT, 8'd3, 8'd0);
      tick(10);
      enter_key = 1'b0;
      tick(4);
      checkOutput();
      push_expected("cd_after_1", C_COUNT, 8'd3, 8'd0);
      frames(1, 0, 1'b0);
      checkOutput();
      push_expected("cd_after_60", C_COUNT, 8'd2, 8'd0);
      frames(59, 0, 1'b0);
      checkOutput();
      push_expected("cd_after_120", C_COUNT, 8'd1, 8'd0);
      frames(60, 0, 1'b0);
      checkOutput();
      push_expected("cd_after_179", C_COUNT, 8'd1, 8'd0);
      frames(59, 0, 1'b0);
      checkOutput();
      push_expected("run_after_180", C_RUN, 8'd0, 8'd0);
      frames(1, 0, 1'b0);
      checkOutput();

      // Crash outranks finish in the same frame, then the hold window
      push_expected("crash_over_finish", C_CRASH, 8'd0, el(1));
      applyStimulus(4, 1'b1);
      checkOutput();
      push_expected("crash_enter_f50", C_CRASH, 8'd0, el(1));
      frames(50, 0, 1'b0);
      press(6);
      checkOutput();
      push_expected("crash_enter_hold1", C_CRASH, 8'd0, el(1));
      frames(69, 0, 1'b0);
      press(6);
      checkOutput();
      push_expected("crash_exit_idle", C_IDLE, 8'd0, el(1));
      frames(1, 0, 1'b0);
      press(6);
      checkOutput();

      // Near-miss off-road frames, then finish
      push_expected("count2_start", C_COUNT, 8'd3, 8'd0);
      press(6);
      checkOutput();
      push_expected("run2", C_RUN, 8'd0, 8'd0);
      frames(180, 0, 1'b0);
      checkOutput();
      push_expected("off3_stays_run", C_RUN, 8'd0, el(10));
      frames(10, 3, 1'b0);
      checkOutput();
      push_expected("finish", C_FINISH, 8'd0, el(11));
      applyStimulus(0, 1'b1);
      checkOutput();
      push_expected("finish_exit_idle", C_IDLE, 8'd0, el(11));
      press(6);
      checkOutput();

      // Elapsed time across a pause; accumulators must stay cleared while paused
      push_expected("count3_start", C_COUNT, 8'd3, 8'd0);
      press(6);
      checkOutput();
      push_expected("run3", C_RUN, 8'd0, 8'd0);
      frames(180, 0, 1'b0);
      checkOutput();
      push_expected("run_130", C_RUN, 8'd0, el(130));
      frames(130, 0, 1'b0);
      checkOutput();
      push_expected("paused_long_hold", C_PAUSED, 8'd0, el(130));
      press(40);
      checkOutput();
      push_expected("paused_200", C_PAUSED, 8'd0, el(130));
      frames(200, 4, 1'b1);
      hits(6);
      checkOutput();
      push_expected("resume_no_crash", C_RUN, 8'd0, el(131));
      press(6);
      applyStimulus(0, 1'b0);
      checkOutput();
      push_expected("elapsed_180", C_RUN, 8'd0, el(180));
      frames(49, 0, 1'b0);
      checkOutput();

      // Asynchronous reset while paused with the key held
      push_expected("paused_pre_reset", C_PAUSED, 8'd0, el(180));
      press(6);
      checkOutput();
      enter_key = 1'b1;
      tick(2);
      push_expected("async_reset", C_IDLE, 8'd0, 8'd0);
      reset = 1'b1;
      #2;
      checkOutput();
      tick(3);
      reset = 1'b0;
      push_expected("held_after_reset", C_IDLE, 8'd0, 8'd0);
      tick(20);
      checkOutput();
      enter_key = 1'b0;
      tick(4);
      push_expected("new_press_count", C_COUNT, 8'd3, 8'd0);
      press(6);
      checkOutput();

      if (sb.size() != 0) begin
         checks++;
         failures++;
         $display("[TB] FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
